// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter: display timing,
// framebuffer geometry and the cell-to-address mapping.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int CELL_COLS  = 160;
    localparam int CELL_ROWS  = 120;
    localparam int FB_ADDR_W  = 15;
    localparam int CELL_SHIFT = 2;
    localparam int FB_CELLS   = CELL_COLS * CELL_ROWS;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } arb_state_t;

    localparam fb_addr_t FB_LAST = fb_addr_t'(FB_CELLS - 1);

    // cy*160 + cx using shifts only (160 = 128 + 32).
    function automatic fb_addr_t cell_addr(input logic [7:0] cx, input logic [6:0] cy);
        return ({8'd0, cy} << 7) + ({8'd0, cy} << 5) + {7'd0, cx};
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundles for the arbiter: the drawing client's valid/ready write port
// and the single-port framebuffer RAM port.
interface draw_if #(parameter int PIX_W = 8);
    logic             valid;
    logic             ready;
    logic [7:0]       x;
    logic [6:0]       y;
    logic [PIX_W-1:0] data;

    modport master (output valid, x, y, data, input ready);
    modport slave  (input valid, x, y, data, output ready);
endinterface

interface fb_mem_if #(parameter int PIX_W = 8);
    vga_pkg::fb_addr_t addr;
    logic              we;
    logic [PIX_W-1:0]  wdata;
    logic [PIX_W-1:0]  rdata;

    modport master (output addr, we, wdata, input rdata);
    modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/vga_fb_arbiter_pix_pipe.sv
// Two-stage alignment of sync/print with the synchronous RAM read, plus the
// pixel capture register that holds each cell value across its 4 pixels.
module vga_pix_pipe #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             print,
    input  logic             read_slot,
    input  logic [PIX_W-1:0] rdata,
    output logic             h_sync_o,
    output logic             v_sync_o,
    output logic             print_o,
    output logic [PIX_W-1:0] pix_data
);

    logic [1:0]       hs_d;
    logic [1:0]       vs_d;
    logic [1:0]       pr_d;
    logic             slot_d1;
    logic [PIX_W-1:0] pix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d    <= 2'b11;
            vs_d    <= 2'b11;
            pr_d    <= 2'b00;
            slot_d1 <= 1'b0;
            pix_q   <= '0;
        end else begin
            hs_d    <= {hs_d[0], h_sync};
            vs_d    <= {vs_d[0], v_sync};
            pr_d    <= {pr_d[0], print};
            slot_d1 <= read_slot;
            // RAM data is valid the cycle after a read slot; hold it otherwise.
            if (slot_d1) begin
                pix_q <= rdata;
            end
        end
    end

    assign h_sync_o = hs_d[1];
    assign v_sync_o = vs_d[1];
    assign print_o  = pr_d[1];
    assign pix_data = pr_d[1] ? pix_q : '0;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads own every 4th visible pixel cycle,
// all other cycles go to the clear engine or the drawing client.
//
// state   | meaning
// S_CLEAR | clear engine writes CLEAR_COLOR to every cell, draw port stalled
// S_RUN   | draw port accepted in every write slot
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int               PIX_W       = 8,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             print,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    output logic             h_sync_o,
    output logic             v_sync_o,
    output logic             print_o,
    output logic [PIX_W-1:0] pix_data,
    input  logic             clear_req,
    output logic             clear_busy,
    draw_if.slave            draw,
    fb_mem_if.master         mem
);

    arb_state_t state;
    fb_addr_t   clr_addr;
    logic       read_slot;
    logic       in_range;
    logic       accept;
    logic       unused_y;

    assign read_slot  = print && (x[1:0] == 2'b00);
    assign in_range   = (draw.x < 8'(CELL_COLS)) && (draw.y < 7'(CELL_ROWS));
    assign draw.ready = (state == S_RUN) && !read_slot;
    assign accept     = draw.valid && draw.ready;
    assign clear_busy = (state == S_CLEAR);
    assign unused_y   = ^{y[9], y[1:0]};

    // Writes are blocked while reset is held so nothing reaches the RAM
    // before the clear engine is released.
    always_comb begin
        mem.addr  = cell_addr(x[9:2], y[8:2]);
        mem.we    = 1'b0;
        mem.wdata = CLEAR_COLOR;
        if (rst_n && !read_slot) begin
            if (state == S_CLEAR) begin
                mem.we   = 1'b1;
                mem.addr = clr_addr;
            end else if (accept && in_range) begin
                mem.we    = 1'b1;
                mem.addr  = cell_addr(draw.x, draw.y);
                mem.wdata = draw.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (!read_slot) begin
                        if (clr_addr == FB_LAST) begin
                            state    <= S_RUN;
                            clr_addr <= '0;
                        end else begin
                            clr_addr <= clr_addr + fb_addr_t'(1);
                        end
                    end
                end
                S_RUN: begin
                    // A write accepted this cycle still lands; clearing starts next cycle.
                    if (clear_req) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    state    <= S_CLEAR;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    vga_pix_pipe #(.PIX_W(PIX_W)) u_pix_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .print     (print),
        .read_slot (read_slot),
        .rdata     (mem.rdata),
        .h_sync_o  (h_sync_o),
        .v_sync_o  (v_sync_o),
        .print_o   (print_o),
        .pix_data  (pix_data)
    );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: expected RAM writes and pixel values are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_vga_fb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       h_sync, v_sync, print;
    logic [9:0] x, y;
    logic       h_sync_o, v_sync_o, print_o;
    logic [7:0] pix_data;
    logic       clear_req, clear_busy;

    draw_if   #(.PIX_W(8)) draw_bus ();
    fb_mem_if #(.PIX_W(8)) mem_bus ();

    vga_fb_arbiter #(.PIX_W(8), .CLEAR_COLOR(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .print      (print),
        .x          (x),
        .y          (y),
        .h_sync_o   (h_sync_o),
        .v_sync_o   (v_sync_o),
        .print_o    (print_o),
        .pix_data   (pix_data),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .draw       (draw_bus),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:19199];

    always @(posedge clk) begin
        if (mem_bus.addr < 15'd19200) begin
            if (mem_bus.we) ram[mem_bus.addr] <= mem_bus.wdata;
            mem_bus.rdata <= ram[mem_bus.addr];
        end else begin
            mem_bus.rdata <= 8'h00;
        end
    end

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t  wq[$];
    int   pq[$];
    wr_t  mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_last_we = 1'b0;
    int   mon_last_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        mon_last_we   = mem_bus.we;
        mon_last_addr = int'(mem_bus.addr);
        if (mem_bus.we) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'(mem_bus.we), 32'd0);
            end else begin
                mon_e = wq.pop_front();
                check("wr_addr", 32'(mem_bus.addr), 32'(mon_e.addr));
                check("wr_data", 32'(mem_bus.wdata), 32'(mon_e.data));
                check("wr_in_read_slot", 32'(print && (x[1:0] == 2'b00)), 32'd0);
            end
        end
        if (clear_busy) check("ready_in_clear", 32'(draw_bus.ready), 32'd0);
        if (print_o) begin
            if (pq.size() > 0) check("pix_data", 32'(pix_data), 32'(pq.pop_front()));
        end else begin
            check("pix_blank", 32'(pix_data), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int a = 0; a < 19200; a++) wq.push_back('{addr: a, data: 8'h00});
    endtask

    // Runs until the clear finishes; a mid-clear clear_req pulse must be ignored.
    task automatic wait_clear(input bit with_print);
        int i = 0;
        while (clear_busy && i < 30000) begin
            print     = with_print;
            x         = 10'(i % 640);
            y         = 10'd0;
            clear_req = (i == 100);
            tick();
            i++;
        end
        clear_req = 1'b0;
        print     = 1'b0;
        check("clear_done", 32'(clear_busy), 32'd0);
        check("last_clear_we", 32'(mon_last_we), 32'd1);
        check("last_clear_addr", 32'(mon_last_addr), 32'd19199);
    endtask

    // Caller is at posedge+1 with print=0, so every cycle is a write slot.
    task automatic do_write(input int cx, input int cy, input int d, input int exp_addr);
        if (exp_addr >= 0) wq.push_back('{addr: exp_addr, data: d});
        draw_bus.valid = 1'b1;
        draw_bus.x     = 8'(cx);
        draw_bus.y     = 7'(cy);
        draw_bus.data  = 8'(d);
        #1;
        check("write_ready", 32'(draw_bus.ready), 32'd1);
        tick();
        draw_bus.valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        h_sync = 1'b1; v_sync = 1'b1; print = 1'b0;
        x = '0; y = '0; clear_req = 1'b0;
        draw_bus.valid = 1'b0; draw_bus.x = '0; draw_bus.y = '0; draw_bus.data = '0;

        @(negedge clk); @(negedge clk);
        check("rst_clear_busy", 32'(clear_busy), 32'd1);
        check("rst_h_sync_o", 32'(h_sync_o), 32'd1);
        check("rst_v_sync_o", 32'(v_sync_o), 32'd1);
        check("rst_print_o", 32'(print_o), 32'd0);
        check("rst_wr_ready", 32'(draw_bus.ready), 32'd0);
        check("rst_mem_we", 32'(mem_bus.we), 32'd0);

        // Initial clear with the display running so read slots interleave.
        push_clear();
        tick();
        rst_n = 1'b1;
        wait_clear(1'b1);

        // Plain writes in blanking.
        do_write(10, 5, 8'h3C, 810);
        do_write(1, 1, 8'hA5, 161);
        do_write(2, 1, 8'h5B, 162);

        // Request held across a read slot.
        wq.push_back('{addr: 323, data: 8'h5A});
        print = 1'b1; x = 10'd0; y = 10'd0;
        draw_bus.valid = 1'b1; draw_bus.x = 8'd3; draw_bus.y = 7'd2; draw_bus.data = 8'h5A;
        pq.push_back(8'h00);
        #1 check("ready_read_slot", 32'(draw_bus.ready), 32'd0);
        tick();
        x = 10'd1;
        pq.push_back(8'h00);
        #1 check("ready_after_slot", 32'(draw_bus.ready), 32'd1);
        tick();
        print = 1'b0; draw_bus.valid = 1'b0;

        // Scan-out of cells 161 and 162.
        for (int i = 4; i < 12; i++) begin
            print = 1'b1; y = 10'd4; x = 10'(i);
            pq.push_back(i < 8 ? 8'hA5 : 8'h5B);
            tick();
        end
        print = 1'b0;
        repeat (3) tick();

        // Out-of-range requests complete the handshake but write nothing.
        do_write(160, 0, 8'hEE, -1);
        do_write(0, 120, 8'hEE, -1);
        tick();
        check("oor_ram_unchanged", 32'(ram[160]), 32'd0);

        // clear_req together with an accepted write, then a request held through the clear.
        wq.push_back('{addr: 19199, data: 8'h77});
        push_clear();
        wq.push_back('{addr: 161, data: 8'h11});
        draw_bus.valid = 1'b1; draw_bus.x = 8'd159; draw_bus.y = 7'd119; draw_bus.data = 8'h77;
        clear_req = 1'b1;
        #1 check("ready_with_clear_req", 32'(draw_bus.ready), 32'd1);
        tick();
        clear_req = 1'b0;
        draw_bus.x = 8'd1; draw_bus.y = 7'd1; draw_bus.data = 8'h11;
        check("ready_after_clear_req", 32'(draw_bus.ready), 32'd0);
        check("busy_after_clear_req", 32'(clear_busy), 32'd1);
        wait_clear(1'b0);
        check("held_write_ready", 32'(draw_bus.ready), 32'd1);
        tick();
        draw_bus.valid = 1'b0;
        tick();

        // Sync delay, then reset in the middle of a clear.
        h_sync = 1'b0; v_sync = 1'b0;
        tick();
        check("hs_delay1", 32'(h_sync_o), 32'd1);
        tick();
        check("hs_delay2", 32'(h_sync_o), 32'd0);
        check("vs_delay2", 32'(v_sync_o), 32'd0);
        push_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            print = 1'b1; x = 10'(i); y = 10'd0;
            tick();
        end
        check("print_o_before_reset", 32'(print_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_bus.we), 32'd0);
        check("midrst_busy", 32'(clear_busy), 32'd1);
        check("midrst_print_o", 32'(print_o), 32'd0);
        check("midrst_pix", 32'(pix_data), 32'd0);
        check("midrst_h_sync_o", 32'(h_sync_o), 32'd1);
        wq.delete();
        push_clear();
        print = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_clear(1'b0);

        repeat (4) tick();
        check("wr_queue_empty", 32'(wq.size()), 32'd0);
        check("pix_queue_empty", 32'(pq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
